// File: rtl/hack_data_memory.sv
// hack_data_memory: responder for the Hack CPU data-memory bus.
// 16K RAM at 0x0000, 8K screen at 0x4000, keyboard FIFO head at 0x6000.
// A second registered port lets a display scanner read the screen buffer.
// Optional macro HACK_DMEM_BUS_ERR_EN adds a sticky unmapped-write error flag.
module hack_data_memory #(
  parameter int KBD_DEPTH = 4,
  parameter int KBD_CW    = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [14:0]       addressM,
  input  logic [15:0]       outM,
  input  logic              writeM,
  output logic [15:0]       inM,
  input  logic [15:0]       kbd_code,
  input  logic              kbd_valid,
  output logic              kbd_ready,
  output logic [KBD_CW-1:0] kbd_count,
  input  logic [12:0]       disp_addr,
`ifdef HACK_DMEM_BUS_ERR_EN
  output logic              bus_err,
  output logic [14:0]       bus_err_addr,
`endif
  output logic [15:0]       disp_data
);

  localparam int              DATA_W   = 16;
  localparam int              PW       = $clog2(KBD_DEPTH);
  localparam logic [KBD_CW-1:0] LP_DEPTH = KBD_CW'(KBD_DEPTH);

  logic [DATA_W-1:0] r_ram    [0:16383];
  logic [DATA_W-1:0] r_screen [0:8191];
  logic [DATA_W-1:0] r_fifo   [0:KBD_DEPTH-1];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [KBD_CW-1:0] r_count;
  logic [DATA_W-1:0] r_disp_data;

  logic              w_is_ram;
  logic              w_is_scr;
  logic              w_is_kbd;
  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic [DATA_W-1:0] w_kbd_head;

  assign w_is_ram   = (addressM[14] == 1'b0);
  assign w_is_scr   = (addressM[14:13] == 2'b10);
  assign w_is_kbd   = (addressM == 15'h6000);

  // Ready is purely a function of occupancy so no path runs from the CPU bus to the source.
  assign w_ready    = reset && (r_count < LP_DEPTH);
  // A zero code completes the handshake but is not stored: 0 means "no key".
  assign w_push     = kbd_valid && w_ready && (kbd_code != 16'h0000);
  assign w_pop      = reset && writeM && w_is_kbd && (r_count != '0);
  assign w_kbd_head = (r_count == '0) ? 16'h0000 : r_fifo[r_rd_ptr];

  assign kbd_ready  = w_ready;
  assign kbd_count  = r_count;
  assign disp_data  = r_disp_data;

  // CPU read mux: combinational so the CPU sees the array contents in the same cycle.
  always_comb begin
    inM = 16'h0000;
    if (w_is_ram)      inM = r_ram[addressM[13:0]];
    else if (w_is_scr) inM = r_screen[addressM[12:0]];
    else if (w_is_kbd) inM = w_kbd_head;
  end

  // RAM and screen storage; contents are deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (reset && writeM && w_is_ram) r_ram[addressM[13:0]] <= outM;
    if (reset && writeM && w_is_scr) r_screen[addressM[12:0]] <= outM;
  end

  // Keyboard FIFO storage; w_push already excludes reset.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= kbd_code;
  end

  // Keyboard FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + KBD_CW'(w_push) - KBD_CW'(w_pop);
    end
  end

  // Display read port: one-cycle latency, returns the pre-write value on a same-cycle CPU write.
  always_ff @(posedge clk) begin
    if (!reset) r_disp_data <= 16'h0000;
    else        r_disp_data <= r_screen[disp_addr];
  end

`ifdef HACK_DMEM_BUS_ERR_EN
  logic        w_unmapped_wr;
  logic        r_bus_err;
  logic [14:0] r_bus_err_addr;

  assign w_unmapped_wr = writeM && (addressM[14:13] == 2'b11) && !w_is_kbd;
  assign bus_err       = r_bus_err;
  assign bus_err_addr  = r_bus_err_addr;

  // Sticky error flag capturing only the first unmapped write address.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bus_err      <= 1'b0;
      r_bus_err_addr <= 15'h0000;
    end else if (w_unmapped_wr && !r_bus_err) begin
      r_bus_err      <= 1'b1;
      r_bus_err_addr <= addressM;
    end
  end
`endif

  // The source must hold its code steady while stalled on a valid without ready.
  a_kbd_stable: assert property (@(posedge clk) disable iff (!reset)
    (kbd_valid && !kbd_ready) |=> (!kbd_valid || $stable(kbd_code)));

endmodule
